// File: rtl/verdict_event_log_if.sv
// Reader-side handshake bundle for the verdict event log.
interface verdict_event_log_if #(
    parameter int TS_W = 16
) ();
    logic              ev_valid;
    logic              ev_ready;
    logic [TS_W+10:0]  ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/verdict_event_log.sv
// Logs timestamped verdict/saturation edge events into a small FWFT FIFO,
// drained by a valid/ready reader, counting records lost to overflow.
module verdict_event_log #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic [7:0]                 din,
    input  logic                       verdict,
    input  logic                       cteal_15,
    verdict_event_log_if.master        ev,
    output logic [$clog2(DEPTH):0]     ev_count,
    output logic [7:0]                 drop_cnt,
    input  logic                       clr_drops
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = TS_W + 11;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TS_W-1:0]  ts;
    logic             verdict_q;
    logic             cteal_q;

    logic rise, fall, sat, evt;
    logic full, empty, push, pop, drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        rise  = enb & verdict & ~verdict_q;
        fall  = enb & ~verdict & verdict_q;
        sat   = enb & cteal_15 & ~cteal_q;
        evt   = rise | fall | sat;
        full  = (ev_count == CW'(DEPTH));
        empty = (ev_count == '0);
        pop   = ~empty & ev.ev_ready;
        // A full FIFO still accepts a record when the head leaves in the same cycle.
        push  = evt & (~full | pop);
        drop  = evt & ~push;
    end

    assign ev.ev_valid = ~empty;
    assign ev.ev_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            verdict_q <= 1'b0;
            cteal_q   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ev_count  <= '0;
            drop_cnt  <= '0;
        end else begin
            if (enb) begin
                ts        <= ts + TS_W'(1);
                verdict_q <= verdict;
                cteal_q   <= cteal_15;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   ev_count <= ev_count + CW'(1);
                2'b01:   ev_count <= ev_count - CW'(1);
                default: ev_count <= ev_count;
            endcase
            if (clr_drops)
                drop_cnt <= drop ? 8'd1 : 8'd0;
            else if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Storage is never cleared; validity is tracked by ev_count alone.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= {ts, sat, fall, rise, din};
    end
endmodule

// File: tb/tb_verdict_event_log.sv
// Directed bench for verdict_event_log: scenario tasks with hand-computed records.
module tb_verdict_event_log;
    localparam int DEPTH = 8;
    localparam int TS_W  = 16;

    logic       clk = 1'b0;
    logic       rst, enb, verdict, cteal_15, clr_drops;
    logic [7:0] din;
    logic [3:0] ev_count;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] ts_m;
    logic [26:0] exp_q [0:8];

    verdict_event_log_if #(.TS_W(TS_W)) evif ();

    verdict_event_log #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .enb(enb), .din(din), .verdict(verdict),
        .cteal_15(cteal_15), .ev(evif), .ev_count(ev_count),
        .drop_cnt(drop_cnt), .clr_drops(clr_drops)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] mk(input logic [15:0] t, input logic s,
                                       input logic f, input logic r, input logic [7:0] d);
        return {t, s, f, r, d};
    endfunction

    // Advance one clock; the expected timestamp follows the enable sampled at the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && enb) ts_m = ts_m + 16'd1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enb = 1'b1; verdict = 1'b0; cteal_15 = 1'b0; din = 8'h00;
        clr_drops = 1'b0; evif.ev_ready = 1'b0; ts_m = 16'd0;
        repeat (10) tick();
        total++; if (evif.ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evif.ev_valid); end
        total++; if (ev_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ev_count); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
        total++; if (evif.ev_data !== 27'd0) begin bad++; $display("FAIL reset_data got=%h want=0", evif.ev_data); end
        rst = 1'b0;
        ts_m = 16'd0;
    endtask

    task automatic test_rise_fall();
        repeat (3) tick();
        verdict = 1'b1; din = 8'h05;
        tick();
        total++; if (evif.ev_valid !== 1'b1) begin bad++; $display("FAIL rise_latency got=%b want=1", evif.ev_valid); end
        total++; if (evif.ev_data !== mk(16'd3, 1'b0, 1'b0, 1'b1, 8'h05)) begin bad++; $display("FAIL rise_rec got=%h want=%h", evif.ev_data, mk(16'd3, 1'b0, 1'b0, 1'b1, 8'h05)); end
        repeat (9) tick();
        verdict = 1'b0; din = 8'h08;
        tick();
        total++; if (ev_count !== 4'd2) begin bad++; $display("FAIL rf_count got=%0d want=2", ev_count); end
        evif.ev_ready = 1'b1;
        tick();
        total++; if (evif.ev_data !== mk(16'd13, 1'b0, 1'b1, 1'b0, 8'h08)) begin bad++; $display("FAIL fall_rec got=%h want=%h", evif.ev_data, mk(16'd13, 1'b0, 1'b1, 1'b0, 8'h08)); end
        tick();
        evif.ev_ready = 1'b0;
        total++; if (ev_count !== 4'd0 || evif.ev_valid !== 1'b0) begin bad++; $display("FAIL rf_drain count=%0d valid=%b want 0/0", ev_count, evif.ev_valid); end
    endtask

    task automatic test_combined();
        repeat (4) tick();
        verdict = 1'b1; cteal_15 = 1'b1; din = 8'h01;
        tick();
        total++; if (ev_count !== 4'd1) begin bad++; $display("FAIL comb_count got=%0d want=1", ev_count); end
        total++; if (evif.ev_data !== mk(16'd20, 1'b1, 1'b0, 1'b1, 8'h01)) begin bad++; $display("FAIL comb_rec got=%h want=%h", evif.ev_data, mk(16'd20, 1'b1, 1'b0, 1'b1, 8'h01)); end
        // Push and pop at occupancy one: the new record becomes the head.
        verdict = 1'b0; cteal_15 = 1'b0; din = 8'h02; evif.ev_ready = 1'b1;
        exp_q[0] = mk(ts_m, 1'b0, 1'b1, 1'b0, 8'h02);
        tick();
        total++; if (ev_count !== 4'd1) begin bad++; $display("FAIL pp1_count got=%0d want=1", ev_count); end
        total++; if (evif.ev_data !== exp_q[0]) begin bad++; $display("FAIL pp1_head got=%h want=%h", evif.ev_data, exp_q[0]); end
        tick();
        evif.ev_ready = 1'b0;
        total++; if (ev_count !== 4'd0) begin bad++; $display("FAIL pp1_drain got=%0d want=0", ev_count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 11; i++) begin
            verdict = ~verdict; din = 8'h10 + 8'(i);
            if (i < 8) exp_q[i] = mk(ts_m, 1'b0, ~verdict, verdict, din);
            tick();
        end
        total++; if (ev_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", ev_count); end
        total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL ovf_drop got=%0d want=3", drop_cnt); end
        total++; if (evif.ev_data !== exp_q[0]) begin bad++; $display("FAIL ovf_head got=%h want=%h", evif.ev_data, exp_q[0]); end
        clr_drops = 1'b1;
        tick();
        clr_drops = 1'b0;
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL clr_drop got=%0d want=0", drop_cnt); end
        verdict = 1'b0; clr_drops = 1'b1;
        tick();
        clr_drops = 1'b0;
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL clr_with_drop got=%0d want=1", drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        verdict = 1'b1; din = 8'hAA; evif.ev_ready = 1'b1;
        exp_q[8] = mk(ts_m, 1'b0, 1'b0, 1'b1, 8'hAA);
        tick();
        total++; if (ev_count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d want=8", ev_count); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL fpp_drop got=%0d want=1", drop_cnt); end
        for (int j = 1; j <= 8; j++) begin
            total++; if (evif.ev_data !== exp_q[j]) begin bad++; $display("FAIL drain_%0d got=%h want=%h", j, evif.ev_data, exp_q[j]); end
            tick();
        end
        total++; if (ev_count !== 4'd0 || evif.ev_valid !== 1'b0) begin bad++; $display("FAIL drain_empty count=%0d valid=%b", ev_count, evif.ev_valid); end
        tick();
        total++; if (ev_count !== 4'd0) begin bad++; $display("FAIL ready_empty got=%0d want=0", ev_count); end
        evif.ev_ready = 1'b0;
    endtask

    task automatic test_enb_gating();
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            verdict = ~verdict; cteal_15 = ~cteal_15;
            tick();
        end
        total++; if (ev_count !== 4'd0 || evif.ev_valid !== 1'b0) begin bad++; $display("FAIL gate_none count=%0d valid=%b", ev_count, evif.ev_valid); end
        verdict = 1'b1; cteal_15 = 1'b0; enb = 1'b1;
        tick();
        verdict = 1'b0; din = 8'h5A;
        exp_q[0] = mk(ts_m, 1'b0, 1'b1, 1'b0, 8'h5A);
        tick();
        total++; if (evif.ev_data !== exp_q[0]) begin bad++; $display("FAIL gate_ts got=%h want=%h", evif.ev_data, exp_q[0]); end
        evif.ev_ready = 1'b1; enb = 1'b0;
        tick();
        evif.ev_ready = 1'b0; enb = 1'b1;
        total++; if (ev_count !== 4'd0) begin bad++; $display("FAIL gate_pop got=%0d want=0", ev_count); end
    endtask

    task automatic test_wrap();
        while (ts_m != 16'hFFFF) tick();
        verdict = 1'b1; din = 8'h33;
        tick();
        verdict = 1'b0; din = 8'h44;
        tick();
        total++; if (ev_count !== 4'd2) begin bad++; $display("FAIL wrap_count got=%0d want=2", ev_count); end
        total++; if (evif.ev_data !== mk(16'hFFFF, 1'b0, 1'b0, 1'b1, 8'h33)) begin bad++; $display("FAIL wrap_ffff got=%h want=%h", evif.ev_data, mk(16'hFFFF, 1'b0, 1'b0, 1'b1, 8'h33)); end
        evif.ev_ready = 1'b1;
        tick();
        evif.ev_ready = 1'b0;
        total++; if (evif.ev_data !== mk(16'h0000, 1'b0, 1'b1, 1'b0, 8'h44)) begin bad++; $display("FAIL wrap_zero got=%h want=%h", evif.ev_data, mk(16'h0000, 1'b0, 1'b1, 1'b0, 8'h44)); end
    endtask

    task automatic test_mid_reset();
        verdict = 1'b1;
        tick();
        total++; if (ev_count !== 4'd2) begin bad++; $display("FAIL pre_rst_count got=%0d want=2", ev_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (ev_count !== 4'd0 || evif.ev_valid !== 1'b0 || evif.ev_data !== 27'd0) begin bad++; $display("FAIL mid_rst count=%0d valid=%b data=%h", ev_count, evif.ev_valid, evif.ev_data); end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_combined();
        test_overflow();
        test_full_push_pop();
        test_enb_gating();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/verdict_event_log.md
Name: verdict_event_log

Overview:
- Downstream consumer of the compare/counter stage; watches its `verdict` and `cteal_15` outputs plus the `din` byte that produced them.
- On every verdict edge or new `cteal_15` assertion, logs a timestamped event record into a small first-word-fall-through (FWFT) FIFO.
- Records are drained by a valid/ready reader (debug/host side).
- Records dropped because the FIFO was full are counted.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- TS_W, 16, timestamp counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  stage enable; same enable that drives the upstream compare/counter stage.
- din  in  8  data byte presented to the upstream stage this cycle.
- verdict  in  1  upstream verdict output.
- cteal_15  in  1  upstream count-equals-15 flag.
- ev_valid  out  1  head record available.
- ev_ready  in  1  reader accepts head record.
- ev_data  out  TS_W+11  head record, {ts[TS_W-1:0], sat, fall, rise, din[7:0]}.
- ev_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  8  events lost to overflow; saturates at 255.
- clr_drops  in  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (rst=1 at posedge) values:
  - ev_valid=0, ev_count=0, drop_cnt=0.
  - ev_data=0; the storage array need not be cleared.
  - Timestamp ts=0.
  - History registers verdict_q=0, cteal_q=0.
- Reset wins over every other input. Reset asserted mid-operation discards all FIFO contents immediately.
- Timestamp:
  - ts increments by 1 at each posedge with enb=1.
  - Holds when enb=0.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- History: verdict_q<=verdict and cteal_q<=cteal_15 only on posedges with enb=1; otherwise held.
- Event detection (combinational, all terms qualified by enb):
  - rise = enb & verdict & ~verdict_q
  - fall = enb & ~verdict & verdict_q
  - sat  = enb & cteal_15 & ~cteal_q
  - event = rise | fall | sat
  - rise and sat, or fall and sat, can coincide. They are logged as ONE record with both bits set, never two records.
- Record content: {ts (value before this edge's increment), sat, fall, rise, din}.
- Push rules:
  - On a posedge with event=1, push if not full, or if full with a pop in the same cycle.
  - Otherwise drop the record and increment drop_cnt, saturating at 255.
- Pop: occurs on a posedge where ev_valid & ev_ready.
  - ev_ready while empty has no effect.
- FIFO read side (FWFT):
  - ev_data always shows the head entry while ev_valid=1.
  - Latency: an event sampled at posedge k gives ev_valid=1 after posedge k, when the FIFO was empty.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Allowed at full and when count=1. At count=1, the new record becomes the head after the edge.
  - Never allowed at empty, because pop requires ev_valid.
- Occupancy:
  - ev_count ranges 0..DEPTH.
  - Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
  - full = (ev_count==DEPTH); empty = (ev_count==0).
- clr_drops=1 sets drop_cnt=0.
  - If a drop happens in the same cycle, the result is drop_cnt=1.
- enb=0:
  - No events are generated.
  - Popping continues normally, so the reader can drain while the stage is idle.

Test Plan:
- Reset sequence: rst=1 for 10 cycles, then release with enb=1, verdict=0 -> ev_valid=0, ev_count=0, drop_cnt=0; ts counts 0,1,2,...
- Verdict rise/fall: with ev_ready=0, verdict goes 0→1 at ts=3 with din=0x05 and stays high, then drops at ts=13 with din=0x08 -> two records: {3,0,0,1,0x05} then {13,0,1,0,0x08}; ev_count=2.
- Combined event: verdict and cteal_15 rise in the same cycle, ts=20, din=0x01 -> exactly one record {20,1,0,1,0x01}; ev_count increments by 1.
- Overflow: DEPTH=8, ev_ready=0, 11 events generated -> ev_count=8, drop_cnt=3; the first 8 records are retained in order. Then pulse clr_drops -> drop_cnt=0.
- Full push+pop: FIFO full, ev_ready=1, event in the same cycle -> ev_count stays 8, drop_cnt unchanged, head advances by one, new record at the tail.
- enb gating/wrap: hold enb=0 for 5 cycles while toggling verdict -> no records, ts frozen. Preload ts near 0xFFFF by running; event at ts=0xFFFF followed by event at next edge -> records carry ts 0xFFFF then 0x0000.
